// File: rtl/scroll_msg_pkg.sv
// Shared types and glyph codes for the scrolling-message write path and its
// 7-segment scroller.
package scroll_msg_pkg;

  localparam int unsigned CHAR_W    = 5;
  localparam int unsigned MSG_DEPTH = 8;
  localparam int unsigned ADDR_W    = $clog2(MSG_DEPTH);
  localparam int unsigned LEN_W     = ADDR_W + 1;

  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LEN_W-1:0]  len_t;

  // Codes shared with the scroller's code-to-segment ROM
  localparam char_t CH_BLANK = 5'd0;
  localparam char_t CH_A     = 5'd1;
  localparam char_t CH_H     = 5'd8;
  localparam char_t CH_N     = 5'd14;
  localparam char_t CH_O     = 5'd15;
  localparam char_t CH_Z     = 5'd26;

  typedef enum logic [1:0] {ActNone, ActWr, ActDel, ActClr} action_e;

  // One action per cycle; lower-priority strobes are dropped
  function automatic action_e arbitrate(input logic clr, input logic del, input logic wr);
    if (clr)      return ActClr;
    else if (del) return ActDel;
    else if (wr)  return ActWr;
    else          return ActNone;
  endfunction

endpackage

// File: rtl/scroll_msg_writer_if.sv
// Key/char inputs and message read port of the scrolling-message writer.
interface scroll_msg_writer_if;
  import scroll_msg_pkg::*;

  char_t char_in;
  logic  key_wr_n;
  logic  key_del_n;
  logic  key_clr_n;
  addr_t rd_addr;
  char_t rd_char;
  len_t  msg_len;
  logic  full;
  logic  empty;
  logic  msg_changed;
  logic  err;

  modport master (
    output char_in, key_wr_n, key_del_n, key_clr_n, rd_addr,
    input  rd_char, msg_len, full, empty, msg_changed, err
  );

  modport slave (
    input  char_in, key_wr_n, key_del_n, key_clr_n, rd_addr,
    output rd_char, msg_len, full, empty, msg_changed, err
  );

endinterface

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-FF synchronizer, stability counter, one-cycle press strobe.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    // Strobe only on the accepted falling edge; release is ignored
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/scroll_msg_writer.sv
// Message buffer for the scroller: debounced append/delete/clear keys, length
// register, register file and combinational read port.
module scroll_msg_writer
  import scroll_msg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                CLK,
  input  logic                CLR_N,
  scroll_msg_writer_if.slave  bus
);

  logic    wr_press, del_press, clr_press;
  action_e act;
  char_t   mem_q [MSG_DEPTH];
  char_t   mem_d [MSG_DEPTH];
  len_t    len_q, len_d;
  logic    changed_q, changed_d;
  logic    err_q, err_d;
  logic    is_full;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_wr (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .key_n (bus.key_wr_n),
    .press (wr_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_del (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .key_n (bus.key_del_n),
    .press (del_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .key_n (bus.key_clr_n),
    .press (clr_press)
  );

  assign act     = arbitrate(clr_press, del_press, wr_press);
  assign is_full = (len_q == LEN_W'(MSG_DEPTH));

  always_comb begin
    mem_d     = mem_q;
    len_d     = len_q;
    changed_d = 1'b0;
    err_d     = 1'b0;
    unique case (act)
      ActClr: begin
        for (int i = 0; i < MSG_DEPTH; i++) mem_d[i] = CH_BLANK;
        len_d     = '0;
        changed_d = 1'b1;
      end
      ActDel: begin
        if (len_q == '0) begin
          err_d = 1'b1;
        end else begin
          mem_d[addr_t'(len_q - LEN_W'(1))] = CH_BLANK;
          len_d     = len_q - LEN_W'(1);
          changed_d = 1'b1;
        end
      end
      ActWr: begin
        if (is_full) begin
          err_d = 1'b1;
        end else begin
          mem_d[len_q[ADDR_W-1:0]] = bus.char_in;
          len_d     = len_q + LEN_W'(1);
          changed_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      for (int i = 0; i < MSG_DEPTH; i++) mem_q[i] <= CH_BLANK;
      len_q     <= '0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      len_q     <= len_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    bus.rd_char = CH_BLANK;
    if ({1'b0, bus.rd_addr} < len_q) bus.rd_char = mem_q[bus.rd_addr];
  end

  assign bus.msg_len     = len_q;
  assign bus.full        = is_full;
  assign bus.empty       = (len_q == '0);
  assign bus.msg_changed = changed_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_scroll_msg_writer.sv
// Scoreboard bench for scroll_msg_writer: key presses push expected pulses,
// a negedge monitor pops and compares them.
module tb_scroll_msg_writer;
  import scroll_msg_pkg::*;

  localparam int unsigned DB  = 4;
  localparam int          LAT = DB + 3;

  typedef struct {
    int cyc;
    int len;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  scroll_msg_writer_if bus();

  scroll_msg_writer #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK   (clk),
    .CLR_N (clr_n),
    .bus   (bus)
  );

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_len    = 0;
  logic [4:0] m_mem [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rd_check(input int a, input logic [4:0] exp, input string nm);
    bus.rd_addr = a[2:0];
    #1;
    check(nm, bus.rd_char, exp);
  endtask

  task automatic apply_model(input bit c, input bit d, input bit w, input logic [4:0] ch,
                             input int fc);
    exp_t e;
    e.cyc = fc + LAT;
    e.err = 1'b0;
    if (c) begin
      m_len = 0;
      for (int i = 0; i < 8; i++) m_mem[i] = 5'd0;
    end else if (d) begin
      if (m_len == 0) e.err = 1'b1;
      else begin
        m_len--;
        m_mem[m_len] = 5'd0;
      end
    end else if (w) begin
      if (m_len == 8) e.err = 1'b1;
      else begin
        m_mem[m_len] = ch;
        m_len++;
      end
    end
    e.len = m_len;
    sb.push_back(e);
  endtask

  task automatic press(input bit c, input bit d, input bit w, input logic [4:0] ch);
    @(posedge clk); #1;
    bus.char_in   = ch;
    bus.key_clr_n = ~c;
    bus.key_del_n = ~d;
    bus.key_wr_n  = ~w;
    apply_model(c, d, w, ch, cyc);
    repeat (LAT + 3) @(posedge clk);
    #1;
    bus.key_clr_n = 1'b1;
    bus.key_del_n = 1'b1;
    bus.key_wr_n  = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (clr_n && (bus.msg_changed || bus.err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got changed=%0b err=%0b expected no pulse (cyc=%0d)",
                 bus.msg_changed, bus.err, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_msg_len", bus.msg_len, mon_e.len);
        check("pulse_err", bus.err, mon_e.err);
        check("pulse_changed", bus.msg_changed, !mon_e.err);
        check("pulse_full", bus.full, mon_e.len == 8);
        check("pulse_empty", bus.empty, mon_e.len == 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = 5'd0;
    clr_n         = 1'b0;
    bus.char_in   = 5'd0;
    bus.key_wr_n  = 1'b1;
    bus.key_del_n = 1'b1;
    bus.key_clr_n = 1'b1;
    bus.rd_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_len", bus.msg_len, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_changed", bus.msg_changed, 0);
    check("rst_err", bus.err, 0);
    for (int a = 0; a < 8; a++) rd_check(a, 5'd0, "rst_rd");
    clr_n = 1'b1;
    repeat (2) @(posedge clk);

    // Three appends
    press(0, 0, 1, CH_Z);
    press(0, 0, 1, CH_O);
    press(0, 0, 1, CH_H);
    check("t2_len", bus.msg_len, 3);
    rd_check(0, CH_Z, "t2_rd0");
    rd_check(1, CH_O, "t2_rd1");
    rd_check(2, CH_H, "t2_rd2");
    rd_check(3, 5'd0, "t2_rd3");

    // Fill to capacity, then overflow
    press(1, 0, 0, 5'd0);
    check("clr_len", bus.msg_len, 0);
    for (int i = 1; i <= 8; i++) press(0, 0, 1, 5'(i));
    check("t3_full", bus.full, 1);
    check("t3_len8", bus.msg_len, 8);
    press(0, 0, 1, CH_Z);
    check("t3_len_sat", bus.msg_len, 8);
    rd_check(7, 5'd8, "t3_rd7");
    rd_check(0, 5'd1, "t3_rd0");

    // Bounce then steady low: exactly one write
    press(1, 0, 0, 5'd0);
    @(posedge clk); #1;
    bus.char_in = CH_N;
    for (int r = 0; r < 3; r++) begin
      bus.key_wr_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.key_wr_n = 1'b1;
      @(posedge clk); #1;
    end
    bus.key_wr_n = 1'b0;
    apply_model(0, 0, 1, CH_N, cyc);
    repeat (LAT + 6) @(posedge clk);
    #1;
    bus.key_wr_n = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("t4_len", bus.msg_len, 1);
    rd_check(0, CH_N, "t4_rd0");

    // del beats wr in the same cycle; then underflow
    press(0, 0, 1, CH_A);
    press(0, 0, 1, CH_O);
    press(0, 1, 1, CH_H);
    check("t5_len", bus.msg_len, 2);
    rd_check(0, CH_N, "t5_rd0");
    rd_check(1, CH_A, "t5_rd1");
    rd_check(2, 5'd0, "t5_rd2");
    press(0, 1, 0, 5'd0);
    press(0, 1, 0, 5'd0);
    check("t5_empty", bus.empty, 1);
    press(0, 1, 0, 5'd0);
    check("t5_len_after_err", bus.msg_len, 0);

    // Async reset mid-debounce with content present
    for (int i = 0; i < 5; i++) press(0, 0, 1, 5'(i + 3));
    check("t6_len5", bus.msg_len, 5);
    @(posedge clk); #1;
    bus.char_in  = CH_Z;
    bus.key_wr_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clr_n = 1'b0;
    #1;
    check("t6_len_reset", bus.msg_len, 0);
    check("t6_empty_reset", bus.empty, 1);
    rd_check(0, 5'd0, "t6_rd0");
    m_len = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 5'd0;
    bus.key_wr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t6_len_after", bus.msg_len, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
